// File: rtl/tick_sched_pkg.sv
// Shared constants for the tick scheduler: state encoding, speed range and counter width helper.
package tick_sched_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   localparam int unsigned SPEED_W  = 4;
   localparam int unsigned STEP_MAX = 16;

   // Counter width able to hold 0..div-1, never less than one bit.
   function automatic int unsigned cnt_w(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/tick_counter.sv
// Modulo counter 0..term with clear, hold-when-disabled and a registered terminal pulse.
module tick_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] term,
   output logic         tick,
   output logic         hit_c
);

   logic [W-1:0] r_cnt;

   assign hit_c = en && !clr && (r_cnt == term);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= hit_c;
         if (clr) begin
            r_cnt <= '0;
         end else if (en) begin
            r_cnt <= hit_c ? '0 : r_cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/tick_scheduler.sv
// Game timebase: clock-enable pulses for scan, frame, speed-scaled step and seconds under a RUN/PAUSE/IDLE FSM.
// Define TICK_SCHED_SEC_EN to build the second counter, sec_tick and seconds.
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 204000,
   parameter int unsigned FRAME_DIV = 1000000,
   parameter int unsigned SEC_DIV   = 100000000
) (
   input  logic               clk_in,
   input  logic               rst_n,
   input  logic               start,
   input  logic               pause,
   input  logic               resume,
   input  logic               stop,
   input  logic [SPEED_W-1:0] speed,
   output logic               scan_tick,
   output logic               frame_tick,
   output logic               step_tick,
   output logic               sec_tick,
   output logic [15:0]        seconds,
   output logic [1:0]         state
);

   localparam int unsigned SCAN_W  = cnt_w(SCAN_DIV);
   localparam int unsigned FRAME_W = cnt_w(FRAME_DIV);
   localparam int unsigned STEP_W  = cnt_w(STEP_MAX);

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic               w_adv;
   logic               w_new_game;
   logic [SPEED_W-1:0] r_speed_q;
   logic [STEP_W-1:0]  w_step_term;
   logic               w_frame_hit;
   logic               w_step_hit;
   logic               w_scan_hit_unused;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Command priority: stop > start > pause > resume.
   always_comb begin
      w_state_nxt = r_state;
      w_adv       = 1'b0;
      w_new_game  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (stop)       w_state_nxt = ST_IDLE;
            else if (start) begin
               w_state_nxt = ST_RUN;
               w_new_game  = 1'b1;
            end
         end
         ST_RUN: begin
            if (stop)       w_state_nxt = ST_IDLE;
            else if (pause) w_state_nxt = ST_PAUSE;
            else            w_adv       = 1'b1;
         end
         ST_PAUSE: begin
            if (stop)        w_state_nxt = ST_IDLE;
            else if (resume) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign state = r_state;

   // Speed is only re-sampled at step boundaries so a step in progress keeps its length.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n)                       r_speed_q <= '0;
      else if (w_new_game || w_step_hit) r_speed_q <= speed;
   end

   assign w_step_term = STEP_W'(STEP_MAX - 1) - r_speed_q;

   tick_counter #(.W(SCAN_W)) u_scan (
      .clk   (clk_in),
      .rst_n (rst_n),
      .en    (1'b1),
      .clr   (1'b0),
      .term  (SCAN_W'(SCAN_DIV - 1)),
      .tick  (scan_tick),
      .hit_c (w_scan_hit_unused)
   );

   tick_counter #(.W(FRAME_W)) u_frame (
      .clk   (clk_in),
      .rst_n (rst_n),
      .en    (w_adv),
      .clr   (w_new_game),
      .term  (FRAME_W'(FRAME_DIV - 1)),
      .tick  (frame_tick),
      .hit_c (w_frame_hit)
   );

   tick_counter #(.W(STEP_W)) u_step (
      .clk   (clk_in),
      .rst_n (rst_n),
      .en    (w_frame_hit),
      .clr   (w_new_game),
      .term  (w_step_term),
      .tick  (step_tick),
      .hit_c (w_step_hit)
   );

`ifdef TICK_SCHED_SEC_EN
   localparam int unsigned SEC_W = cnt_w(SEC_DIV);

   logic        w_sec_hit;
   logic [15:0] r_seconds;

   tick_counter #(.W(SEC_W)) u_sec (
      .clk   (clk_in),
      .rst_n (rst_n),
      .en    (w_adv),
      .clr   (w_new_game),
      .term  (SEC_W'(SEC_DIV - 1)),
      .tick  (sec_tick),
      .hit_c (w_sec_hit)
   );

   // Seconds saturate at 0xFFFF and are cleared whenever the game returns to IDLE.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n)                                      r_seconds <= '0;
      else if (w_state_nxt == ST_IDLE || w_new_game)   r_seconds <= '0;
      else if (w_sec_hit && (r_seconds != 16'hFFFF))   r_seconds <= r_seconds + 16'(1);
   end

   assign seconds = r_seconds;
`else
   localparam int unsigned sec_div_unused = SEC_DIV;

   assign sec_tick = 1'b0;
   assign seconds  = 16'h0000;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed scoreboard bench for tick_scheduler; sec expectations follow TICK_SCHED_SEC_EN.
module tb_tick_scheduler;

   localparam int unsigned SCAN_DIV  = 4;
   localparam int unsigned FRAME_DIV = 5;
   localparam int unsigned SEC_DIV   = 20;

   logic        clk_in = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start  = 1'b0;
   logic        pause  = 1'b0;
   logic        resume = 1'b0;
   logic        stop   = 1'b0;
   logic [3:0]  speed  = 4'd0;
   logic        scan_tick, frame_tick, step_tick, sec_tick;
   logic [15:0] seconds;
   logic [1:0]  state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int q_frame[$];
   int q_step[$];
   int q_sec[$];
   int run_n       = 0;
   int frm_in_step = 0;
   int step_len    = 16;
   int exp_sec     = 0;
   bit e_frame, e_step, e_sec;

   tick_scheduler #(
      .SCAN_DIV  (SCAN_DIV),
      .FRAME_DIV (FRAME_DIV),
      .SEC_DIV   (SEC_DIV)
   ) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .start      (start),
      .pause      (pause),
      .resume     (resume),
      .stop       (stop),
      .speed      (speed),
      .scan_tick  (scan_tick),
      .frame_tick (frame_tick),
      .step_tick  (step_tick),
      .sec_tick   (sec_tick),
      .seconds    (seconds),
      .state      (state)
   );

   always #5 clk_in = ~clk_in;

   // Edge index since reset release; output of edge k is observed while cyc == k.
   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // Advance one edge; when it is an advancing RUN edge, push the ticks it must produce.
   task automatic step_clk(input bit adv);
      @(posedge clk_in);
      #1;
      if (adv) begin
         run_n++;
         if (run_n % FRAME_DIV == 0) begin
            q_frame.push_back(cyc);
            frm_in_step++;
            if (frm_in_step == step_len) begin
               q_step.push_back(cyc);
               frm_in_step = 0;
               step_len    = 16 - int'(speed);
            end
         end
`ifdef TICK_SCHED_SEC_EN
         if (run_n % SEC_DIV == 0) begin
            q_sec.push_back(cyc);
            if (exp_sec < 65535) exp_sec++;
         end
`endif
      end
   endtask

   task automatic new_game();
      run_n       = 0;
      frm_in_step = 0;
      step_len    = 16 - int'(speed);
      exp_sec     = 0;
   endtask

   always @(negedge clk_in) begin
      e_frame = (q_frame.size() != 0) && (q_frame[0] == cyc);
      e_step  = (q_step.size()  != 0) && (q_step[0]  == cyc);
      e_sec   = (q_sec.size()   != 0) && (q_sec[0]   == cyc);
      chk("scan_tick",  32'(scan_tick),  32'((cyc % SCAN_DIV == 0) && (cyc != 0)));
      chk("frame_tick", 32'(frame_tick), 32'(e_frame));
      chk("step_tick",  32'(step_tick),  32'(e_step));
      chk("sec_tick",   32'(sec_tick),   32'(e_sec));
      chk("seconds",    32'(seconds),    32'(exp_sec));
      if (e_frame) void'(q_frame.pop_front());
      if (e_step)  void'(q_step.pop_front());
      if (e_sec)   void'(q_sec.pop_front());
   end

   initial begin
      repeat (3) @(posedge clk_in);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_frame", 32'(frame_tick), 32'd0);
      #1 rst_n = 1'b1;

      // Idle: only scan ticks.
      repeat (20) step_clk(1'b0);
      chk("idle_state", 32'(state), 32'd0);

      // Start at speed 14: two frames per step.
      speed = 4'd14;
      start = 1'b1;
      step_clk(1'b0);
      start = 1'b0;
      new_game();
      chk("run_state", 32'(state), 32'd1);
      repeat (60) step_clk(1'b1);
`ifdef TICK_SCHED_SEC_EN
      chk("seconds_after_60", 32'(seconds), 32'd3);
`else
      chk("seconds_after_60", 32'(seconds), 32'd0);
`endif

      // Pause: adv is low on the pause edge, six held edges and the resume edge.
      pause = 1'b1;
      step_clk(1'b0);
      pause = 1'b0;
      chk("pause_state", 32'(state), 32'd2);
      repeat (6) step_clk(1'b0);
      resume = 1'b1;
      step_clk(1'b0);
      resume = 1'b0;
      chk("resume_state", 32'(state), 32'd1);

      // Speed change mid-step: current step keeps two frames, later steps take one.
      repeat (5) step_clk(1'b1);
      speed = 4'd15;
      repeat (5) step_clk(1'b1);
      repeat (15) step_clk(1'b1);

      // Pause and resume together in RUN -> PAUSE.
      pause  = 1'b1;
      resume = 1'b1;
      step_clk(1'b0);
      pause  = 1'b0;
      resume = 1'b0;
      chk("pause_resume_state", 32'(state), 32'd2);

      // Stop and start together in PAUSE -> IDLE, seconds cleared.
      stop  = 1'b1;
      start = 1'b1;
      step_clk(1'b0);
      stop  = 1'b0;
      start = 1'b0;
      exp_sec = 0;
      chk("stop_start_state", 32'(state), 32'd0);
      chk("stop_seconds", 32'(seconds), 32'd0);
      repeat (12) step_clk(1'b0);

      // New game at speed 10, then asynchronous reset mid-RUN.
      speed = 4'd10;
      start = 1'b1;
      step_clk(1'b0);
      start = 1'b0;
      new_game();
      repeat (43) step_clk(1'b1);
      @(negedge clk_in);
      #1;
      exp_sec = 0;
      rst_n   = 1'b0;
      #1;
      chk("midrst_state",   32'(state),      32'd0);
      chk("midrst_scan",    32'(scan_tick),  32'd0);
      chk("midrst_frame",   32'(frame_tick), 32'd0);
      chk("midrst_step",    32'(step_tick),  32'd0);
      chk("midrst_sec",     32'(sec_tick),   32'd0);
      chk("midrst_seconds", 32'(seconds),    32'd0);
      repeat (2) @(posedge clk_in);
      #1 rst_n = 1'b1;
      repeat (10) step_clk(1'b0);
      chk("post_rst_state", 32'(state), 32'd0);

      @(negedge clk_in);
      #1;
      chk("frame_queue_drained", 32'(q_frame.size()), 32'd0);
      chk("step_queue_drained",  32'(q_step.size()),  32'd0);
      chk("sec_queue_drained",   32'(q_sec.size()),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Central timebase controller for the game. It replaces free-running derived clocks with single-cycle clock-enable pulses on the single system clock: display scan, 100 Hz frame, speed-scaled game step and 1 s ticks. A RUN/PAUSE/IDLE state machine gates the game ticks; the display scan tick always runs. It sits between the board clock and the game, display and score logic, and is the only place game timing is sequenced.

## Interface
- SCAN_DIV, 204000, clk_in cycles per scan_tick
- FRAME_DIV, 1000000, clk_in cycles per frame_tick (100 Hz at 100 MHz)
- SEC_DIV, 100000000, clk_in cycles per sec_tick
- clk_in  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level-sampled; starts a new game from IDLE
- pause  in  1  RUN -> PAUSE
- resume  in  1  PAUSE -> RUN
- stop  in  1  any state -> IDLE
- speed  in  4  game speed level, 0 = slowest, 15 = fastest
- scan_tick  out  1  one-cycle pulse every SCAN_DIV cycles, never gated
- frame_tick  out  1  one-cycle pulse, RUN only
- step_tick  out  1  one-cycle pulse every (16 - speed) frames, RUN only
- sec_tick  out  1  one-cycle pulse every SEC_DIV RUN cycles
- seconds  out  16  elapsed RUN seconds, saturating
- state  out  2  0 IDLE, 1 RUN, 2 PAUSE

## Operation
- States: IDLE (reset), RUN, PAUSE. Priority per cycle: stop > start > pause > resume.
- IDLE: start -> RUN. All game counters, step reload and seconds are cleared on entry to RUN from IDLE.
- RUN: stop -> IDLE; pause -> PAUSE; start and resume are ignored.
- PAUSE: stop -> IDLE; resume -> RUN with the counters continuing from their held values; start and pause are ignored.
- Advance enable `adv` = (state == RUN) && !pause && !stop. The frame, step and second counters count only when adv is high and hold otherwise.
- Each divider is a modulo-DIV counter 0..DIV-1. The terminal count is DIV-1, so the period is exactly DIV cycles.
- Scan counter is never gated and never cleared except by reset.
- Step counter counts frame terminals. Its reload value is 16 - speed_q, giving a range of 1..16 frames.
- speed_q is latched from speed at entry to RUN from IDLE and at each step terminal, so a speed change never shortens or glitches a step in progress.
- seconds increments on each sec terminal and saturates at 0xFFFF.
- Entering IDLE clears seconds to 0.

## Timing
- All outputs are registered. Reset values: every tick output 0, seconds 0, state IDLE; the scan counter and all other counters are 0.
- Tick latency: the pulse is asserted on the cycle after the counter holds DIV-1 with its enable high.
- step_tick coincides with the frame_tick that completes the step.
- sec_tick is independent of frame_tick.
- The state output updates one cycle after the command is sampled.
- A tick pending on the same cycle that stop or pause is sampled is suppressed, because adv is low.
- Reset mid-operation returns to IDLE immediately. No tick is asserted during reset or on the first cycle after it.
- No tick output is ever high for two consecutive cycles unless DIV = 1.

## Configuration
- TICK_SCHED_SEC_EN defined: the SEC_DIV counter, sec_tick and the seconds counter are built.
- TICK_SCHED_SEC_EN undefined: sec_tick and seconds are tied to 0 and no second counter exists. All other behaviour is unchanged.

## Structure
- Package tick_sched_pkg holds:
  - the state encoding constants (ST_IDLE, ST_RUN, ST_PAUSE)
  - SPEED_W = 4
  - STEP_MAX = 16
- Sub-module tick_counter: a parameterized modulo counter with inputs en and clr, and a registered terminal pulse.
- tick_scheduler instantiates tick_counter for scan, frame and second, plus one instance with runtime reload logic for the step counter.

## Test plan
Bench parameters: SCAN_DIV=4, FRAME_DIV=5, SEC_DIV=20.
- Reset released, no commands -> scan_tick every 4 cycles from the start; frame, step and sec ticks stay 0; state = 0.
- start, speed=14 -> frame_tick every 5 cycles; step_tick on every 2nd frame_tick (10 cycles); sec_tick every 20 cycles; seconds = 3 after 60 RUN cycles.
- pause for 7 cycles then resume -> no game ticks during PAUSE; the next frame_tick arrives late by exactly the number of cycles adv was low; scan_tick is unaffected.
- speed changed 14 -> 15 mid-step -> the current step still completes after 2 frames; subsequent steps last 1 frame.
- pause and resume asserted together in RUN -> PAUSE; stop and start together in PAUSE -> IDLE; seconds = 0.
- rst_n asserted mid-RUN -> all outputs 0 and state IDLE immediately; with TICK_SCHED_SEC_EN undefined, seconds stays 0 throughout.
